// File: rtl/bias_stream_tx_pkg.sv
// Shared state encoding, default widths and per-layer bias-region constants
// for the bias-load transmit path.
package bias_stream_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int WD_DEF = 8;
  localparam int AW_DEF = 10;

  localparam int                 C1_NUM_BIAS  = 6;
  localparam logic [AW_DEF-1:0]  C1_BIAS_BASE = 10'h010;
  localparam logic [AW_DEF-1:0]  C2_BIAS_BASE = 10'h016;

endpackage

// File: rtl/bias_rd_pipe.sv
// Tracks the one-cycle memory read latency and registers returned words onto the stream.
// Word appears on bias_en_o two cycles after its read strobe; no backpressure, data holds when idle.
module bias_rd_pipe
  import bias_stream_tx_pkg::*;
#(
  parameter int WD = WD_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rd_i,
  input  logic [WD-1:0] mem_data_i,
  output logic          inflight_o,
  output logic [WD-1:0] bias_data_o,
  output logic          bias_en_o
);

  logic          rd_dly_q;
  logic          en_q;
  logic [WD-1:0] dat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_dly_q <= 1'b0;
      en_q     <= 1'b0;
      dat_q    <= '0;
    end else begin
      rd_dly_q <= rd_i;
      en_q     <= rd_dly_q;
      if (rd_dly_q) begin
        dat_q <= mem_data_i;
      end
    end
  end

  assign inflight_o  = rd_dly_q;
  assign bias_data_o = dat_q;
  assign bias_en_o   = en_q;

endmodule

// File: rtl/bias_stream_tx.sv
// Bias-load transmitter: reads i_num words from parameter memory and streams them out.
// First word two cycles after the first read; i_hold stalls reads, idle gap precedes o_done.
module bias_stream_tx
  import bias_stream_tx_pkg::*;
#(
  parameter int WD      = WD_DEF,
  parameter int AW      = AW_DEF,
  parameter int CW      = 4,
  parameter int GAP_CYC = 2
) (
  input  logic          i_sclk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_base_addr,
  input  logic [CW-1:0] i_num,
  input  logic          i_hold,
  output logic          o_mem_rd,
  output logic [AW-1:0] o_mem_addr,
  input  logic [WD-1:0] i_mem_data,
  output logic [WD-1:0] o_bias_data,
  output logic          o_bias_en,
  output logic          o_busy,
  output logic          o_done
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e        st_q, st_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] num_q, num_d;
  logic [CW-1:0] k_q, k_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          inflight;

  always_comb begin
    st_d   = st_q;
    base_d = base_q;
    addr_d = addr_q;
    num_d  = num_q;
    k_d    = k_q;
    gap_d  = gap_q;
    rd_d   = 1'b0;

    case (st_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_num == '0) begin
            st_d = ST_DONE;
          end else begin
            base_d = i_base_addr;
            num_d  = i_num;
            k_d    = '0;
            st_d   = ST_READ;
            // Issue the first read straight from IDLE so it lands the cycle after start.
            if (!i_hold) begin
              rd_d   = 1'b1;
              addr_d = i_base_addr;
              k_d    = CW'(1);
              if (i_num == CW'(1)) st_d = ST_DRAIN;
            end
          end
        end
      end
      ST_READ: begin
        if (!i_hold) begin
          rd_d   = 1'b1;
          addr_d = base_q + AW'(k_q);
          k_d    = k_q + CW'(1);
          if ((k_q + CW'(1)) == num_q) st_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Last word is on the stream once no read is registered or awaiting data.
        if (!rd_q && !inflight) begin
          st_d  = ST_GAP;
          gap_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) st_d = ST_DONE;
        else                           gap_d = gap_q + GW'(1);
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase

    busy_d = (st_d == ST_READ) || (st_d == ST_DRAIN) || (st_d == ST_GAP);
    done_d = (st_d == ST_DONE);
  end

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      st_q   <= ST_IDLE;
      base_q <= '0;
      addr_q <= '0;
      num_q  <= '0;
      k_q    <= '0;
      gap_q  <= '0;
      rd_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      base_q <= base_d;
      addr_q <= addr_d;
      num_q  <= num_d;
      k_q    <= k_d;
      gap_q  <= gap_d;
      rd_q   <= rd_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  bias_rd_pipe #(.WD(WD)) u_rd_pipe (
    .clk_i       (i_sclk),
    .rst_i       (i_rst),
    .rd_i        (rd_q),
    .mem_data_i  (i_mem_data),
    .inflight_o  (inflight),
    .bias_data_o (o_bias_data),
    .bias_en_o   (o_bias_en)
  );

  assign o_mem_rd   = rd_q;
  assign o_mem_addr = addr_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_bias_stream_tx.sv
// Self-checking bench for bias_stream_tx: memory model, event monitor and a burst-level
// reference model that derives read/word/done timing from the start cycle and hold pattern.
module tb_bias_stream_tx;
  import bias_stream_tx_pkg::*;

  localparam int WD  = 8;
  localparam int AW  = 10;
  localparam int CW  = 4;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] base = '0;
  logic [CW-1:0] num = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [WD-1:0] mem_data;
  logic [WD-1:0] bias_data;
  logic          bias_en;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  bias_stream_tx #(.WD(WD), .AW(AW), .CW(CW), .GAP_CYC(GAP)) dut (
    .i_sclk      (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_base_addr (base),
    .i_num       (num),
    .i_hold      (hold),
    .o_mem_rd    (mem_rd),
    .o_mem_addr  (mem_addr),
    .i_mem_data  (mem_data),
    .o_bias_data (bias_data),
    .o_bias_en   (bias_en),
    .o_busy      (busy),
    .o_done      (done)
  );

  logic [WD-1:0] mem [1024];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            checks = 0;
  int            errors = 0;

  // Observed events, stamped with the cycle number they were seen in.
  int            rd_cyc[$];
  logic [AW-1:0] rd_adr[$];
  int            en_cyc[$];
  logic [WD-1:0] en_dat[$];
  int            done_cyc[$];
  logic          busy_at_done[$];
  logic          busy_pre[$];
  logic          busy_prev = 1'b0;

  always @(negedge clk) begin
    if (mem_rd) begin rd_cyc.push_back(cyc); rd_adr.push_back(mem_addr); end
    if (bias_en) begin en_cyc.push_back(cyc); en_dat.push_back(bias_data); end
    if (done) begin
      done_cyc.push_back(cyc);
      busy_at_done.push_back(busy);
      busy_pre.push_back(busy_prev);
    end
    busy_prev = busy;
  end

  // Expected events from the reference model.
  int            x_rd_cyc[$];
  logic [AW-1:0] x_rd_adr[$];
  int            x_en_cyc[$];
  logic [WD-1:0] x_en_dat[$];
  int            x_done;

  task automatic clear_mon();
    rd_cyc.delete(); rd_adr.delete(); en_cyc.delete(); en_dat.delete();
    done_cyc.delete(); busy_at_done.delete(); busy_pre.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // A read goes out in cycle x when hold was low in cycle x-1; its word follows two
  // cycles later; done follows the last word after GAP idle cycles.
  task automatic model(input int c, input logic [AW-1:0] b, input int n, input logic [63:0] hm);
    int issued;
    int x;
    logic [AW-1:0] a;
    x_rd_cyc.delete(); x_rd_adr.delete(); x_en_cyc.delete(); x_en_dat.delete();
    issued = 0;
    x = c + 1;
    while (issued < n) begin
      if (!(((x - 1 - c) < 64) && hm[x - 1 - c])) begin
        a = b + AW'(issued);
        x_rd_cyc.push_back(x);
        x_rd_adr.push_back(a);
        x_en_cyc.push_back(x + 2);
        x_en_dat.push_back(mem[a]);
        issued++;
      end
      x++;
    end
    x_done = (n == 0) ? c + 1 : x_en_cyc[x_en_cyc.size() - 1] + GAP + 1;
  endtask

  // Starts a burst in the current cycle and runs until done is seen (bounded).
  // Spurious starts carry a different base/num so a wrongly accepted one is visible.
  task automatic drive(input logic [AW-1:0] b, input int n, input logic [63:0] hm,
                       input logic [63:0] sm, output int c);
    clear_mon();
    c = cyc; base = b; num = CW'(n); start = 1'b1; hold = hm[0];
    for (int j = 1; j < 200; j++) begin
      @(posedge clk); #1;
      if (done_cyc.size() > 0) break;
      start = (j < 64) ? sm[j] : 1'b0;
      base  = start ? ~b : b;
      num   = start ? ~CW'(n) : CW'(n);
      hold  = (j < 64) ? hm[j] : 1'b0;
    end
    start = 1'b0; hold = 1'b0; base = b; num = CW'(n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (bias_en !== 1'b0) begin errors++; $display("FAIL reset_bias_en: got %b expected 0", bias_en); end
    checks++; if (bias_data !== '0) begin errors++; $display("FAIL reset_bias_data: got %h expected 0", bias_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic(input string nm);
    int c;
    int got;
    drive(C1_BIAS_BASE, C1_NUM_BIAS, 64'd0, 64'd0, c);
    model(c, C1_BIAS_BASE, C1_NUM_BIAS, 64'd0);
    checks++;
    if (rd_cyc.size() !== 6 || en_cyc.size() !== 6) begin
      errors++; $display("FAIL %s_counts: reads %0d words %0d, expected 6 and 6", nm, rd_cyc.size(), en_cyc.size());
    end
    for (int i = 0; i < x_rd_cyc.size() && i < rd_cyc.size(); i++) begin
      checks++;
      if (rd_cyc[i] !== x_rd_cyc[i] || rd_adr[i] !== x_rd_adr[i]) begin
        errors++; $display("FAIL %s_read%0d: got cyc %0d addr %h, expected cyc %0d addr %h", nm, i, rd_cyc[i], rd_adr[i], x_rd_cyc[i], x_rd_adr[i]);
      end
    end
    for (int i = 0; i < x_en_cyc.size() && i < en_cyc.size(); i++) begin
      checks++;
      if (en_cyc[i] !== x_en_cyc[i] || en_dat[i] !== WD'(i + 1)) begin
        errors++; $display("FAIL %s_word%0d: got cyc %0d data %h, expected cyc %0d data %h", nm, i, en_cyc[i], en_dat[i], x_en_cyc[i], WD'(i + 1));
      end
    end
    got = (done_cyc.size() == 1) ? done_cyc[0] : -1;
    checks++; if (got !== x_done) begin errors++; $display("FAIL %s_done: got cyc %0d expected cyc %0d", nm, got, x_done); end
    checks++;
    if (busy_at_done.size() != 1 || busy_at_done[0] !== 1'b0 || busy_pre[0] !== 1'b1) begin
      errors++; $display("FAIL %s_busy: busy falling with done not seen (done pulses %0d)", nm, busy_at_done.size());
    end
  endtask

  task automatic test_hold();
    int c;
    int got;
    logic [63:0] hm;
    hm = 64'h18;  // hold in cycles c+3 and c+4, i.e. right after the 3rd read
    drive(C1_BIAS_BASE, C1_NUM_BIAS, hm, 64'd0, c);
    model(c, C1_BIAS_BASE, C1_NUM_BIAS, hm);
    checks++;
    if (en_cyc.size() !== 6) begin errors++; $display("FAIL hold_count: got %0d words expected 6", en_cyc.size()); end
    for (int i = 0; i < x_en_cyc.size() && i < en_cyc.size(); i++) begin
      checks++;
      if (en_cyc[i] !== x_en_cyc[i] || en_dat[i] !== WD'(i + 1)) begin
        errors++; $display("FAIL hold_word%0d: got cyc %0d data %h, expected cyc %0d data %h", i, en_cyc[i], en_dat[i], x_en_cyc[i], WD'(i + 1));
      end
    end
    checks++;
    if (en_cyc.size() == 6 && (en_cyc[3] - en_cyc[2]) !== 3) begin
      errors++; $display("FAIL hold_bubble: got spacing %0d expected 3", en_cyc[3] - en_cyc[2]);
    end
    got = (done_cyc.size() == 1) ? done_cyc[0] : -1;
    checks++; if (got !== c + 13) begin errors++; $display("FAIL hold_done: got cyc %0d expected cyc %0d", got, c + 13); end
  endtask

  task automatic test_zero();
    int c;
    int got;
    drive(C1_BIAS_BASE, 0, 64'd0, 64'd0, c);
    idle(6);
    got = (done_cyc.size() == 1) ? done_cyc[0] : -1;
    checks++;
    if (rd_cyc.size() !== 0 || en_cyc.size() !== 0) begin
      errors++; $display("FAIL zero_activity: got reads %0d words %0d expected 0 and 0", rd_cyc.size(), en_cyc.size());
    end
    checks++; if (got !== c + 1) begin errors++; $display("FAIL zero_done: got cyc %0d expected cyc %0d", got, c + 1); end
  endtask

  task automatic test_ignored_start();
    int c;
    int got;
    logic [63:0] sm;
    sm = 64'h0E24;  // starts during READ/DRAIN (2,5), GAP (9,10) and DONE (11)
    drive(C1_BIAS_BASE, C1_NUM_BIAS, 64'd0, sm, c);
    idle(8);
    model(c, C1_BIAS_BASE, C1_NUM_BIAS, 64'd0);
    got = (done_cyc.size() == 1) ? done_cyc[0] : -1;
    checks++;
    if (en_cyc.size() !== 6 || rd_cyc.size() !== 6) begin
      errors++; $display("FAIL ignore_count: got reads %0d words %0d expected 6 and 6", rd_cyc.size(), en_cyc.size());
    end
    checks++; if (got !== x_done) begin errors++; $display("FAIL ignore_done: got cyc %0d expected cyc %0d", got, x_done); end
  endtask

  task automatic test_back_to_back();
    int c1;
    int c2;
    int last_en;
    int got;
    drive(C1_BIAS_BASE, C1_NUM_BIAS, 64'd0, 64'd0, c1);
    last_en = (en_cyc.size() > 0) ? en_cyc[en_cyc.size() - 1] : -100;
    drive(C2_BIAS_BASE, 5, 64'd0, 64'd0, c2);
    model(c2, C2_BIAS_BASE, 5, 64'd0);
    checks++;
    if (en_cyc.size() !== 5) begin errors++; $display("FAIL b2b_count: got %0d words expected 5", en_cyc.size()); end
    for (int i = 0; i < x_en_cyc.size() && i < en_cyc.size(); i++) begin
      checks++;
      if (en_cyc[i] !== x_en_cyc[i] || en_dat[i] !== x_en_dat[i]) begin
        errors++; $display("FAIL b2b_word%0d: got cyc %0d data %h, expected cyc %0d data %h", i, en_cyc[i], en_dat[i], x_en_cyc[i], x_en_dat[i]);
      end
    end
    checks++;
    if (en_cyc.size() > 0 && (en_cyc[0] - last_en - 1) < GAP + 1) begin
      errors++; $display("FAIL b2b_separation: got %0d idle cycles expected at least %0d", en_cyc[0] - last_en - 1, GAP + 1);
    end
    got = (done_cyc.size() == 1) ? done_cyc[0] : -1;
    checks++; if (got !== x_done) begin errors++; $display("FAIL b2b_done: got cyc %0d expected cyc %0d", got, x_done); end
  endtask

  task automatic test_wrap();
    int c;
    logic [AW-1:0] exp_a [4];
    exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    drive(10'h3FE, 4, 64'd0, 64'd0, c);
    checks++;
    if (rd_adr.size() !== 4) begin errors++; $display("FAIL wrap_count: got %0d reads expected 4", rd_adr.size()); end
    for (int i = 0; i < 4 && i < rd_adr.size(); i++) begin
      checks++;
      if (rd_adr[i] !== exp_a[i] || en_dat[i] !== mem[exp_a[i]]) begin
        errors++; $display("FAIL wrap_addr%0d: got addr %h data %h, expected addr %h data %h", i, rd_adr[i], en_dat[i], exp_a[i], mem[exp_a[i]]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int c;
    int viol;
    clear_mon();
    c = cyc; base = C1_BIAS_BASE; num = CW'(C1_NUM_BIAS); start = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst = (j == 5);  // reset during the cycle of the 3rd word
    end
    viol = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (mem_rd || bias_en || busy || done) viol++;
      @(posedge clk); #1;
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL rst_quiet: got %0d active cycles expected 0", viol); end
    checks++; if (en_cyc.size() !== 3) begin errors++; $display("FAIL rst_words: got %0d words expected 3", en_cyc.size()); end
    checks++; if (done_cyc.size() !== 0) begin errors++; $display("FAIL rst_done: got %0d done pulses expected 0", done_cyc.size()); end
    test_basic("after_rst");
  endtask

  task automatic test_random();
    int c;
    int n;
    int got;
    logic [AW-1:0] b;
    logic [63:0] hm;
    logic [63:0] sm;
    for (int it = 0; it < 20; it++) begin
      idle($urandom_range(0, 3));
      b  = (it == 0) ? C2_BIAS_BASE : AW'($urandom_range(0, 1023));
      n  = $urandom_range(0, 15);
      hm = {$urandom, $urandom} & {$urandom, $urandom} & 64'hFF_FFFF;
      sm = {$urandom, $urandom} & {$urandom, $urandom};
      drive(b, n, hm, sm, c);
      model(c, b, n, hm);
      checks++;
      if (rd_cyc.size() !== x_rd_cyc.size() || en_cyc.size() !== x_en_cyc.size()) begin
        errors++; $display("FAIL rand%0d_counts: reads %0d words %0d, expected %0d and %0d", it, rd_cyc.size(), en_cyc.size(), x_rd_cyc.size(), x_en_cyc.size());
      end
      for (int i = 0; i < x_rd_cyc.size() && i < rd_cyc.size(); i++) begin
        checks++;
        if (rd_cyc[i] !== x_rd_cyc[i] || rd_adr[i] !== x_rd_adr[i]) begin
          errors++; $display("FAIL rand%0d_read%0d: got cyc %0d addr %h, expected cyc %0d addr %h", it, i, rd_cyc[i], rd_adr[i], x_rd_cyc[i], x_rd_adr[i]);
        end
      end
      for (int i = 0; i < x_en_cyc.size() && i < en_cyc.size(); i++) begin
        checks++;
        if (en_cyc[i] !== x_en_cyc[i] || en_dat[i] !== x_en_dat[i]) begin
          errors++; $display("FAIL rand%0d_word%0d: got cyc %0d data %h, expected cyc %0d data %h", it, i, en_cyc[i], en_dat[i], x_en_cyc[i], x_en_dat[i]);
        end
      end
      got = (done_cyc.size() == 1) ? done_cyc[0] : -1;
      checks++; if (got !== x_done) begin errors++; $display("FAIL rand%0d_done: got cyc %0d expected cyc %0d", it, got, x_done); end
      checks++;
      if (busy_at_done.size() != 1 || busy_at_done[0] !== 1'b0 || busy_pre[0] !== (n > 0)) begin
        errors++; $display("FAIL rand%0d_busy: busy around done wrong (done pulses %0d)", it, busy_at_done.size());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = WD'($urandom);
    for (int k = 0; k < C1_NUM_BIAS; k++) mem[C1_BIAS_BASE + AW'(k)] = WD'(k + 1);
    test_reset();
    test_basic("basic");
    idle(3);
    test_hold();
    idle(3);
    test_zero();
    test_ignored_start();
    idle(2);
    test_back_to_back();
    idle(3);
    test_wrap();
    idle(3);
    test_mid_reset();
    idle(3);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
